// File: rtl/lcd_capture.sv
// lcd_capture: HD44102-style column-driver responder that mirrors host LCD writes into a 240x64 framebuffer.
// Optional read path (status/data reads, FETCH state, read latch) is built when LCD_CAPTURE_READBACK_EN is defined.
module lcd_capture #(
    parameter int SYNC_STAGES  = 2,
    parameter int VISIBLE_COLS = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_pin,
    input  logic        rw_pin,
    input  logic        di_pin,
    input  logic [9:0]  cs_pin,
    input  logic [7:0]  data_pin,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        fb_we,
    output logic [10:0] fb_addr,
    output logic [7:0]  fb_wdata,
    output logic        fb_re,
    input  logic [7:0]  fb_rdata,
    output logic [9:0]  display_on,
    output logic        busy,
    output logic        overrun
);
    localparam int         NCHIP    = 10;
    localparam logic [5:0] LAST_COL = 6'd49;
    localparam logic [5:0] VIS_COLS = 6'(VISIBLE_COLS);
    localparam logic [7:0] CHIP_W   = 8'(VISIBLE_COLS);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FETCH} state_t;

    state_t                 state_q, state_n;
    logic [3:0]             idx_q, idx_n;
    logic [SYNC_STAGES-1:0] e_sync;
    logic                   e_d, e_s, e_fall, accept, start;
    logic                   rw_h, di_h;
    logic [9:0]             cs_h;
    logic [7:0]             data_h;
    logic [NCHIP-1:0][1:0]  page_q;
    logic [NCHIP-1:0][5:0]  col_q;
    logic [NCHIP-1:0]       up_q, on_q;
    logic                   cur_sel, chip_hi, col_vis, wr_data, rd_fetch, fetch_req;
    logic [1:0]             cur_page;
    logic [5:0]             cur_col;
    logic [3:0]             chip_mod;
    logic [7:0]             fb_x;

    function automatic logic [5:0] col_step(input logic [5:0] c, input logic up);
        if (up) col_step = (c >= LAST_COL) ? 6'd0 : c + 6'd1;
        else    col_step = (c == 6'd0) ? LAST_COL : c - 6'd1;
    endfunction

    assign e_s        = e_sync[SYNC_STAGES-1];
    assign e_fall     = e_d & ~e_s;
    assign busy       = (state_q != S_IDLE);
    assign start      = accept & ~busy & (|cs_h);
    assign display_on = on_q;

    // Bus strobe synchronizer; pin values are captured only while idle so a dropped cycle cannot corrupt a scan.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_sync <= '0;
            e_d    <= 1'b0;
            rw_h   <= 1'b0;
            di_h   <= 1'b0;
            cs_h   <= '0;
            data_h <= '0;
        end else begin
            e_sync <= {e_sync[SYNC_STAGES-2:0], enable_pin};
            e_d    <= e_s;
            if (e_s && state_q == S_IDLE) begin
                rw_h   <= rw_pin;
                di_h   <= di_pin;
                cs_h   <= cs_pin;
                data_h <= data_pin;
            end
        end
    end

    assign cur_sel  = (state_q == S_SCAN) & cs_h[idx_q];
    assign cur_page = page_q[idx_q];
    assign cur_col  = col_q[idx_q];
    assign chip_hi  = (idx_q >= 4'd5);
    assign chip_mod = chip_hi ? idx_q - 4'd5 : idx_q;
    assign fb_x     = 8'(chip_mod) * CHIP_W + {2'b00, cur_col};
    assign col_vis  = (cur_col < VIS_COLS);
    assign wr_data  = cur_sel & di_h & ~rw_h;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            overrun <= 1'b0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            if (accept && busy) overrun <= 1'b1;
        end
    end

    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        fb_we    = wr_data & col_vis;
        fb_re    = rd_fetch & col_vis;
        fb_addr  = '0;
        fb_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_SCAN;
                    idx_n   = '0;
                end
            end
            S_SCAN: begin
                fb_addr  = {chip_hi, cur_page, fb_x};
                fb_wdata = data_h;
                if (idx_q == 4'(NCHIP - 1)) begin
                    idx_n   = '0;
                    state_n = fetch_req ? S_FETCH : S_IDLE;
                end else begin
                    idx_n = idx_q + 4'd1;
                end
            end
            S_FETCH: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Start-page commands (col field 62) fall through the col<50 test and are dropped without state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_q <= '0;
            col_q  <= '0;
            up_q   <= '1;
            on_q   <= '0;
        end else if (cur_sel) begin
            if (!di_h && !rw_h) begin
                if (data_h[7:1] == 7'b0011100) begin
                    on_q[idx_q] <= data_h[0];
                end else if (data_h[7:1] == 7'b0011101) begin
                    up_q[idx_q] <= data_h[0];
                end else if (data_h[5:0] <= LAST_COL) begin
                    page_q[idx_q] <= data_h[7:6];
                    col_q[idx_q]  <= data_h[5:0];
                end
            end else if (wr_data || rd_fetch) begin
                col_q[idx_q] <= col_step(cur_col, up_q[idx_q]);
            end
        end
    end

`ifdef LCD_CAPTURE_READBACK_EN
    function automatic logic [3:0] lowest_sel(input logic [9:0] cs);
        lowest_sel = '0;
        for (int i = NCHIP - 1; i >= 0; i--)
            if (cs[i]) lowest_sel = 4'(i);
    endfunction

    logic [3:0] rd_chip, pin_chip;
    logic [7:0] rd_latch;
    logic       rd_pend, rd_now;

    assign accept    = e_fall;
    assign rd_chip   = lowest_sel(cs_h);
    assign rd_fetch  = cur_sel & di_h & rw_h & (idx_q == rd_chip);
    assign fetch_req = di_h & rw_h;
    // Read drive uses the live pins: the host holds them stable for the whole E-high window.
    assign pin_chip  = lowest_sel(cs_pin);
    assign rd_now    = e_s & rw_pin & (|cs_pin);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_oe  <= 1'b0;
            data_out <= '0;
            rd_latch <= '0;
            rd_pend  <= 1'b0;
        end else begin
            data_oe <= rd_now;
            if (!rd_now)     data_out <= '0;
            else if (di_pin) data_out <= rd_latch;
            else             data_out <= {busy, up_q[pin_chip], on_q[pin_chip], 5'b0};
            rd_pend <= fb_re;
            if (rd_pend)                 rd_latch <= fb_rdata;
            else if (rd_fetch && !col_vis) rd_latch <= '0;
        end
    end
`else
    logic e_rw;
    logic unused_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   e_rw <= 1'b0;
        else if (e_s) e_rw <= rw_pin;
    end

    assign accept       = e_fall & ~e_rw;
    assign rd_fetch     = 1'b0;
    assign fetch_req    = 1'b0;
    assign data_oe      = 1'b0;
    assign data_out     = '0;
    assign unused_rdata = ^fb_rdata;
`endif

endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture: table of bus transactions plus hand sequences for overrun and reset-mid-scan.
module tb_lcd_capture;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable_pin, rw_pin, di_pin;
    logic [9:0]  cs_pin;
    logic [7:0]  data_pin;
    logic [7:0]  data_out;
    logic        data_oe;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [7:0]  fb_wdata;
    logic        fb_re;
    logic [7:0]  fb_rdata = 8'h00;
    logic [9:0]  display_on;
    logic        busy, overrun;

    lcd_capture #(.SYNC_STAGES(2), .VISIBLE_COLS(48)) dut (
        .clk(clk), .reset(reset), .enable_pin(enable_pin), .rw_pin(rw_pin), .di_pin(di_pin),
        .cs_pin(cs_pin), .data_pin(data_pin), .data_out(data_out), .data_oe(data_oe),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_re(fb_re), .fb_rdata(fb_rdata),
        .display_on(display_on), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Framebuffer model: read data is a fixed function of the address, valid the cycle after fb_re.
    always @(posedge clk) fb_rdata <= fb_addr[7:0] ^ 8'h5A;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    logic [10:0] we_addr[$];
    logic [7:0]  we_data[$];
    int          we_cyc[$];
    int          re_cnt, busy_cnt;
    logic        oe_seen;
    logic [7:0]  oe_val;

    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (fb_we) begin
            we_addr.push_back(fb_addr);
            we_data.push_back(fb_wdata);
            we_cyc.push_back(cyc);
        end
        if (fb_re) re_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        we_addr.delete();
        we_data.delete();
        we_cyc.delete();
        re_cnt   = 0;
        busy_cnt = 0;
        oe_seen  = 1'b0;
        oe_val   = 8'h00;
    endtask

    task automatic bus(input logic rw, input logic di, input logic [9:0] cs, input logic [7:0] d);
        clear_log();
        rw_pin = rw; di_pin = di; cs_pin = cs; data_pin = d;
        @(posedge clk); #1 enable_pin = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (data_oe) begin oe_seen = 1'b1; oe_val = data_out; end
        end
        enable_pin = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        rw_pin = 1'b0; di_pin = 1'b0; cs_pin = '0; data_pin = '0;
    endtask

    typedef struct {
        logic        rw;
        logic        di;
        logic [9:0]  cs;
        logic [7:0]  d;
        int          n_we;
        logic [10:0] addr;
        logic [7:0]  wd;
        logic [9:0]  disp;
    } vec_t;

    localparam int NV = 19;
    vec_t vt[NV];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        logic seen;

        vt[0]  = '{1'b0, 1'b0, 10'h080, 8'h45, 0, 11'd0,     8'h00, 10'h001};
        vt[1]  = '{1'b0, 1'b1, 10'h080, 8'hA5, 1, 11'h565,   8'hA5, 10'h001};
        vt[2]  = '{1'b0, 1'b1, 10'h080, 8'h5A, 1, 11'h566,   8'h5A, 10'h001};
        vt[3]  = '{1'b0, 1'b0, 10'h001, 8'h3A, 0, 11'd0,     8'h00, 10'h001};
        vt[4]  = '{1'b0, 1'b0, 10'h001, 8'h00, 0, 11'd0,     8'h00, 10'h001};
        vt[5]  = '{1'b0, 1'b1, 10'h001, 8'h11, 1, 11'd0,     8'h11, 10'h001};
        vt[6]  = '{1'b0, 1'b1, 10'h001, 8'h22, 0, 11'd0,     8'h00, 10'h001};
        vt[7]  = '{1'b0, 1'b1, 10'h001, 8'h33, 0, 11'd0,     8'h00, 10'h001};
        vt[8]  = '{1'b0, 1'b1, 10'h001, 8'h44, 1, 11'd47,    8'h44, 10'h001};
        vt[9]  = '{1'b0, 1'b0, 10'h001, 8'h3B, 0, 11'd0,     8'h00, 10'h001};
        vt[10] = '{1'b0, 1'b0, 10'h001, 8'h31, 0, 11'd0,     8'h00, 10'h001};
        vt[11] = '{1'b0, 1'b1, 10'h001, 8'h55, 0, 11'd0,     8'h00, 10'h001};
        vt[12] = '{1'b0, 1'b1, 10'h001, 8'h66, 1, 11'd0,     8'h66, 10'h001};
        vt[13] = '{1'b0, 1'b0, 10'h001, 8'h38, 0, 11'd0,     8'h00, 10'h000};
        vt[14] = '{1'b0, 1'b0, 10'h002, 8'h7E, 0, 11'd0,     8'h00, 10'h000};
        vt[15] = '{1'b0, 1'b1, 10'h002, 8'h99, 1, 11'd48,    8'h99, 10'h000};
        vt[16] = '{1'b0, 1'b0, 10'h004, 8'hFF, 0, 11'd0,     8'h00, 10'h000};
        vt[17] = '{1'b0, 1'b1, 10'h004, 8'h12, 1, 11'd96,    8'h12, 10'h000};
        vt[18] = '{1'b0, 1'b1, 10'h000, 8'h34, 0, 11'd0,     8'h00, 10'h000};

        reset = 1'b0; enable_pin = 1'b0; rw_pin = 1'b0; di_pin = 1'b0; cs_pin = '0; data_pin = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_busy",       32'(busy),       32'd0);
        chk("rst_overrun",    32'(overrun),    32'd0);
        chk("rst_display_on", 32'(display_on), 32'd0);
        chk("rst_fb_we",      32'(fb_we),      32'd0);
        chk("rst_fb_re",      32'(fb_re),      32'd0);
        chk("rst_data_oe",    32'(data_oe),    32'd0);
        chk("rst_data_out",   32'(data_out),   32'd0);

        // Read path: status, display-on, dummy data read then real data read.
        bus(1'b1, 1'b0, 10'h001, 8'h00);
`ifdef LCD_CAPTURE_READBACK_EN
        chk("status0_oe",   32'(oe_seen),  32'd1);
        chk("status0_data", 32'(oe_val),   32'h40);
        chk("status0_busy", 32'(busy_cnt), 32'd10);
`else
        chk("status0_oe",   32'(oe_seen),  32'd0);
        chk("status0_busy", 32'(busy_cnt), 32'd0);
`endif
        bus(1'b0, 1'b0, 10'h001, 8'h39);
        chk("disp_on_chip0", 32'(display_on), 32'h001);
        bus(1'b1, 1'b0, 10'h001, 8'h00);
`ifdef LCD_CAPTURE_READBACK_EN
        chk("status1_data", 32'(oe_val), 32'h60);
`else
        chk("status1_oe",   32'(oe_seen), 32'd0);
`endif
        bus(1'b1, 1'b0, 10'h000, 8'h00);
        chk("nosel_read_oe",   32'(oe_seen),  32'd0);
        chk("nosel_read_busy", 32'(busy_cnt), 32'd0);
        bus(1'b0, 1'b0, 10'h001, 8'h03);
        bus(1'b1, 1'b1, 10'h001, 8'h00);
`ifdef LCD_CAPTURE_READBACK_EN
        chk("dread0_data", 32'(oe_val),   32'h00);
        chk("dread0_re",   32'(re_cnt),   32'd1);
        chk("dread0_busy", 32'(busy_cnt), 32'd11);
`else
        chk("dread0_oe",   32'(oe_seen),  32'd0);
        chk("dread0_re",   32'(re_cnt),   32'd0);
        chk("dread0_busy", 32'(busy_cnt), 32'd0);
`endif
        bus(1'b1, 1'b1, 10'h001, 8'h00);
`ifdef LCD_CAPTURE_READBACK_EN
        chk("dread1_data", 32'(oe_val), 32'h59);
`else
        chk("dread1_oe",   32'(oe_seen), 32'd0);
`endif

        for (int i = 0; i < NV; i++) begin
            bus(vt[i].rw, vt[i].di, vt[i].cs, vt[i].d);
            chk($sformatf("v%0d_we_count", i), 32'(we_addr.size()), 32'(vt[i].n_we));
            if (vt[i].n_we > 0 && we_addr.size() > 0) begin
                chk($sformatf("v%0d_fb_addr", i),  32'(we_addr[0]), 32'(vt[i].addr));
                chk($sformatf("v%0d_fb_wdata", i), 32'(we_data[0]), 32'(vt[i].wd));
            end
            chk($sformatf("v%0d_display_on", i), 32'(display_on), 32'(vt[i].disp));
        end

        // Broadcast write: ten strobes in consecutive cycles, chips 5..9 on the lower half.
        bus(1'b0, 1'b0, 10'h3FF, 8'h00);
        bus(1'b0, 1'b1, 10'h3FF, 8'hFF);
        chk("bcast_we_count", 32'(we_addr.size()), 32'd10);
        chk("bcast_busy",     32'(busy_cnt),       32'd10);
        if (we_addr.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("bcast%0d_addr", i),
                    32'(we_addr[i]), 32'({(i >= 5) ? 3'd4 : 3'd0, 8'((i % 5) * 48)}));
                chk($sformatf("bcast%0d_data", i), 32'(we_data[i]), 32'hFF);
                chk($sformatf("bcast%0d_cycle", i), 32'(we_cyc[i] - we_cyc[0]), 32'(i));
            end
        end

        // Second E fall during the scan is dropped and flags overrun.
        clear_log();
        rw_pin = 1'b0; di_pin = 1'b0; cs_pin = 10'h001; data_pin = 8'h00;
        @(posedge clk); #1 enable_pin = 1'b1;
        repeat (4) @(posedge clk);
        #1 enable_pin = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (busy) begin seen = 1'b1; break; end
        end
        chk("ovr_busy_seen", 32'(seen), 32'd1);
        di_pin = 1'b1; data_pin = 8'h77;
        enable_pin = 1'b1;
        repeat (3) @(posedge clk);
        #1 enable_pin = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        chk("ovr_flag",      32'(overrun),        32'd1);
        chk("ovr_dropped_we", 32'(we_addr.size()), 32'd0);
        cs_pin = '0; di_pin = 1'b0; data_pin = '0;
        bus(1'b0, 1'b1, 10'h001, 8'h88);
        chk("ovr_next_we_count", 32'(we_addr.size()), 32'd1);
        if (we_addr.size() > 0) chk("ovr_next_addr", 32'(we_addr[0]), 32'd0);
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Reset mid-scan: outputs drop at once, per-chip mode returns to up.
        bus(1'b0, 1'b0, 10'h001, 8'h3A);
        bus(1'b0, 1'b0, 10'h001, 8'h39);
        clear_log();
        rw_pin = 1'b0; di_pin = 1'b1; cs_pin = 10'h3FF; data_pin = 8'hAB;
        @(posedge clk); #1 enable_pin = 1'b1;
        repeat (4) @(posedge clk);
        #1 enable_pin = 1'b0;
        seen = 1'b0;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (fb_we) begin seen = 1'b1; break; end
        end
        chk("rstscan_started", 32'(seen), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("rstscan_busy",       32'(busy),       32'd0);
        chk("rstscan_fb_we",      32'(fb_we),      32'd0);
        chk("rstscan_overrun",    32'(overrun),    32'd0);
        chk("rstscan_display_on", 32'(display_on), 32'd0);
        chk("rstscan_fb_addr",    32'(fb_addr),    32'd0);
        cs_pin = '0; di_pin = 1'b0; data_pin = '0;
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("rstscan_busy_after", 32'(busy), 32'd0);
        bus(1'b1, 1'b0, 10'h001, 8'h00);
`ifdef LCD_CAPTURE_READBACK_EN
        chk("rstscan_status", 32'(oe_val), 32'h40);
`else
        chk("rstscan_status_oe", 32'(oe_seen), 32'd0);
`endif
        bus(1'b0, 1'b1, 10'h001, 8'hC1);
        chk("rstscan_w0_count", 32'(we_addr.size()), 32'd1);
        if (we_addr.size() > 0) chk("rstscan_w0_addr", 32'(we_addr[0]), 32'd0);
        bus(1'b0, 1'b1, 10'h001, 8'hC2);
        chk("rstscan_w1_count", 32'(we_addr.size()), 32'd1);
        if (we_addr.size() > 0) chk("rstscan_w1_addr", 32'(we_addr[0]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
